// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared state, opcode and funct3 constants for the OTTER control unit
package otter_pkg;

  typedef enum logic [2:0] {
    st_INIT = 3'd0,
    st_FET  = 3'd1,
    st_EX   = 3'd2,
    st_WB   = 3'd3,
    st_INTR = 3'd4,
    st_ERR  = 3'd5
  } state_type;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    SYSTEM = 7'b1110011
  } opcode_t;

  // funct3 of the privileged SYSTEM group (mret); any other value is a CSR access
  localparam logic [2:0] FUNCT3_PRIV = 3'b000;

endpackage

// File: rtl/otter_cu_wait_timer.sv
// rtl/otter_cu_wait_timer.sv - memory wait counter with timeout compare
module otter_cu_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT = CW'(LIMIT_I);

  logic [CW-1:0] count;

  // Count consecutive not-ready cycles; any state change restarts the count
  always_ff @(posedge clk) begin
    if (RST || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // Expiry is seen during the last permitted wait cycle so the FSM can leave on that edge;
  // a zero timeout never expires and the counter is allowed to wrap harmlessly
  assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/otter_cu_fsm_v2.sv
// rtl/otter_cu_fsm_v2.sv - multicycle OTTER control unit with memory handshakes and interrupts
module otter_cu_fsm_v2
  import otter_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit INTR_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       intr,
  input  logic       csr_mie,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       illegal,
  output logic       bus_err
);

  state_type ps, ns;
  logic      intr_pending;
  logic      waiting;
  logic      expired;
  logic      take_int;
  logic      timer_clear;
  logic      timer_inc;

  otter_cu_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .RST    (RST),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .expired(expired)
  );

  assign timer_clear = (ns != ps);
  assign timer_inc   = waiting && !timer_clear;

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      ps <= st_INIT;
    end else begin
      ps <= ns;
    end
  end

  // Interrupt latch: a level request is remembered until it is actually serviced,
  // so masking via csr_mie delays it without losing it
  always_ff @(posedge clk) begin
    if (RST) begin
      intr_pending <= 1'b0;
    end else if (INTR_EN && intr) begin
      intr_pending <= 1'b1;
    end else if (ns == st_INTR) begin
      intr_pending <= 1'b0;
    end
  end

  // Output decode and next-state selection
  always_comb begin
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    reset     = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    waiting   = 1'b0;
    take_int  = 1'b0;
    ns        = ps;

    case (ps)
      st_INIT: begin
        reset = 1'b1;
        ns    = st_FET;
      end

      st_FET: begin
        memRDEN1 = 1'b1;
        if (imem_ready) begin
          ns = st_EX;
        end else begin
          waiting = 1'b1;
          if (expired) ns = st_ERR;
        end
      end

      st_EX: begin
        case (opcode)
          LOAD: begin
            memRDEN2 = 1'b1;
            if (dmem_ready) begin
              ns = st_WB;
            end else begin
              waiting = 1'b1;
              if (expired) ns = st_ERR;
            end
          end
          STORE: begin
            memWE2 = 1'b1;
            if (dmem_ready) begin
              pcWrite = 1'b1;
            end else begin
              waiting = 1'b1;
              if (expired) ns = st_ERR;
            end
          end
          BRANCH: begin
            pcWrite = 1'b1;
          end
          LUI, AUIPC, OP_IMM, OP_RG3, JAL, JALR: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          SYSTEM: begin
            pcWrite = 1'b1;
            if (funct3 == FUNCT3_PRIV) begin
              mret_exec = 1'b1;
            end else begin
              csr_we   = 1'b1;
              regWrite = 1'b1;
            end
          end
          default: begin
            illegal = 1'b1;
            pcWrite = 1'b1;
          end
        endcase
      end

      st_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
      end

      st_INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
        ns        = st_FET;
      end

      st_ERR: begin
        bus_err = 1'b1;
        ns      = st_ERR;
      end

      default: begin
        ns = st_INIT;
      end
    endcase

    // An instruction completes when it loads the PC; that is the only point an
    // interrupt may be entered, and never straight out of an mret
    if (pcWrite && (ps == st_EX || ps == st_WB)) begin
      take_int = INTR_EN && intr_pending && csr_mie && !mret_exec;
      ns       = take_int ? st_INTR : st_FET;
    end
  end

endmodule
